// File: rtl/issue_stage.sv
// Operand-fetch / issue stage: holds one decoded instruction, waits out
// register write-reserve hazards, bypasses writeback data, issues to execute.
module issue_stage #(
  parameter int unsigned WORD = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned RIDX = 5,
  parameter int unsigned OPW  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [OPW-1:0]       in_op_i,
  input  logic [RIDX-1:0]      in_rs1_i,
  input  logic [RIDX-1:0]      in_rs2_i,
  input  logic [RIDX-1:0]      in_rd_i,
  input  logic                 in_rd_en_i,
  input  logic [NREG*WORD-1:0] reg_data_i,
  input  logic [NREG-1:0]      reg_rsv_i,
  output logic [NREG-1:0]      reserve_o,
  input  logic                 wb_valid_i,
  input  logic [RIDX-1:0]      wb_rd_i,
  input  logic [WORD-1:0]      wb_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [OPW-1:0]       out_op_o,
  output logic [WORD-1:0]      out_a_o,
  output logic [WORD-1:0]      out_b_o,
  output logic [RIDX-1:0]      out_rd_o,
  output logic                 out_rd_en_o
);

  logic            s_valid;
  logic [OPW-1:0]  s_op;
  logic [RIDX-1:0] s_rs1;
  logic [RIDX-1:0] s_rs2;
  logic [RIDX-1:0] s_rd;
  logic            s_rd_en;

  logic            rs1_hit, rs2_hit, rd_hit;
  logic            rs1_ready, rs2_ready, dest_ok, fire;
  logic [WORD-1:0] op_a, op_b;

  // Hazard detection and bypassed operand selection for the held instruction
  always_comb begin
    rs1_hit   = wb_valid_i && (wb_rd_i == s_rs1);
    rs2_hit   = wb_valid_i && (wb_rd_i == s_rs2);
    rd_hit    = wb_valid_i && (wb_rd_i == s_rd);
    rs1_ready = (s_rs1 == '0) || !reg_rsv_i[s_rs1] || rs1_hit;
    rs2_ready = (s_rs2 == '0) || !reg_rsv_i[s_rs2] || rs2_hit;
    dest_ok   = !s_rd_en || (s_rd == '0) || !reg_rsv_i[s_rd] || rd_hit;

    op_a = '0;
    if (s_rs1 != '0) op_a = rs1_hit ? wb_data_i : reg_data_i[int'(s_rs1)*WORD +: WORD];
    op_b = '0;
    if (s_rs2 != '0) op_b = rs2_hit ? wb_data_i : reg_data_i[int'(s_rs2)*WORD +: WORD];

    fire = !rst && s_valid && rs1_ready && rs2_ready && dest_ok &&
           (!out_valid_o || out_ready_i);
    in_ready_o = !rst && (!s_valid || fire);

    // r0 is never reserved
    reserve_o = '0;
    if (fire && s_rd_en && (s_rd != '0)) reserve_o[s_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid     <= 1'b0;
      s_op        <= '0;
      s_rs1       <= '0;
      s_rs2       <= '0;
      s_rd        <= '0;
      s_rd_en     <= 1'b0;
      out_valid_o <= 1'b0;
      out_op_o    <= '0;
      out_a_o     <= '0;
      out_b_o     <= '0;
      out_rd_o    <= '0;
      out_rd_en_o <= 1'b0;
    end else begin
      if (in_valid_i && in_ready_o) begin
        s_valid <= 1'b1;
        s_op    <= in_op_i;
        s_rs1   <= in_rs1_i;
        s_rs2   <= in_rs2_i;
        s_rd    <= in_rd_i;
        s_rd_en <= in_rd_en_i;
      end else if (fire) begin
        s_valid <= 1'b0;
      end

      if (fire) begin
        out_valid_o <= 1'b1;
        out_op_o    <= s_op;
        out_a_o     <= op_a;
        out_b_o     <= op_b;
        out_rd_o    <= s_rd;
        out_rd_en_o <= s_rd_en;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule
